washing_phase_timer: RTL



---
 rtl/washing_pkg.sv | 37 +++
 rtl/washing_tick_gen.sv | 33 +++
 rtl/washing_phase_timer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/washing_pkg.sv
// Shared phase encoding and default phase durations for the wash timer.
// Imported by washing_phase_timer and washing_tick_gen.
package washing_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      DRAIN = 3'd4,
      SPIN  = 3'd5
   } phase_t;

   localparam int DEF_CNT_W     = 16;
   localparam int DEF_FILL_CYC  = 8;
   localparam int DEF_WASH_CYC  = 12;
   localparam int DEF_RINSE_CYC = 10;
   localparam int DEF_DRAIN_CYC = 6;
   localparam int DEF_SPIN_CYC  = 9;
   localparam int DEF_PRESCALE  = 4;

   // Done vector layout is {ts, td, tr, tw, tf}.
   function automatic logic [4:0] done_bit(input phase_t p);
      logic [4:0] d;
      d = 5'b00000;
      unique case (p)
         FILL:    d = 5'b00001;
         WASH:    d = 5'b00010;
         RINSE:   d = 5'b00100;
         DRAIN:   d = 5'b01000;
         SPIN:    d = 5'b10000;
         default: d = 5'b00000;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/washing_tick_gen.sv
// Prescale divider producing one tick every PRESCALE clocks.
// Present only when WASHING_TIMER_PRESCALE_EN is defined.
`ifdef WASHING_TIMER_PRESCALE_EN
module washing_tick_gen
   import washing_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic tick
);

   localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DW-1:0] LAST = DW'(PRESCALE - 1);

   logic [DW-1:0] div_q;

   assign tick = (div_q == LAST) && !hold;

   always_ff @(posedge clk) begin
      if (rst || clr)
         div_q <= '0;
      else if (tick)
         div_q <= '0;
      else if (!hold)
         div_q <= div_q + 1'b1;
   end

endmodule
`endif

// File: rtl/washing_phase_timer.sv
// Decodes the controller's wash phase and times it, driving tf/tw/tr/td/ts.
// WASHING_TIMER_PRESCALE_EN enables the tick prescaler; default ticks every clock.
module washing_phase_timer
   import washing_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int FILL_CYC  = DEF_FILL_CYC,
   parameter int WASH_CYC  = DEF_WASH_CYC,
   parameter int RINSE_CYC = DEF_RINSE_CYC,
   parameter int DRAIN_CYC = DEF_DRAIN_CYC,
   parameter int SPIN_CYC  = DEF_SPIN_CYC,
   parameter int PRESCALE  = DEF_PRESCALE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       water_fill,
   input  logic       agitator,
   input  logic       pump,
   input  logic       motor,
   input  logic       speed,
   input  logic       reset,
   input  logic       door,
   output logic       tf,
   output logic       tw,
   output logic       tr,
   output logic       td,
   output logic       ts,
   output logic [2:0] phase
);

   phase_t           dec;
   phase_t           ph_q, ph_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, dur_m1;
   logic [4:0]       done_q, done_d;
   logic             chg;
   logic             tick;

   // Priority decode of the actuator pattern.
   always_comb begin
      dec = IDLE;
      if (water_fill)
         dec = FILL;
      else if (agitator && !pump)
         dec = WASH;
      else if (agitator && pump)
         dec = RINSE;
      else if (pump && !speed)
         dec = DRAIN;
      else if (motor && speed)
         dec = SPIN;
   end

   assign chg = (dec != ph_q);

   always_comb begin
      dur_m1 = '0;
      unique case (ph_q)
         FILL:    dur_m1 = CNT_W'(FILL_CYC - 1);
         WASH:    dur_m1 = CNT_W'(WASH_CYC - 1);
         RINSE:   dur_m1 = CNT_W'(RINSE_CYC - 1);
         DRAIN:   dur_m1 = CNT_W'(DRAIN_CYC - 1);
         SPIN:    dur_m1 = CNT_W'(SPIN_CYC - 1);
         default: dur_m1 = '0;
      endcase
   end

`ifdef WASHING_TIMER_PRESCALE_EN
   washing_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (reset | chg),
      .hold (door),
      .tick (tick)
   );
`else
   assign tick = (PRESCALE >= 1);
`endif

   always_comb begin
      ph_d   = ph_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      if (reset) begin
         ph_d   = IDLE;
         cnt_d  = '0;
         done_d = '0;
      end else if (chg) begin
         ph_d   = dec;
         cnt_d  = '0;
         done_d = '0;
      end else if (ph_q != IDLE && !door && tick) begin
         // Count saturates at DUR-1; done then holds as a level.
         if (cnt_q == dur_m1)
            done_d = done_bit(ph_q);
         else
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q   <= IDLE;
         cnt_q  <= '0;
         done_q <= '0;
      end else begin
         ph_q   <= ph_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign tf    = done_q[0];
   assign tw    = done_q[1];
   assign tr    = done_q[2];
   assign td    = done_q[3];
   assign ts    = done_q[4];
   assign phase = ph_q;

endmodule
